// File: rtl/xy_bin_arbiter.sv
// Shares the single port of the xy_bin edge BRAM between VGA readout (port 0), the SD loader
// (port 1) and the contour tracer (port 2), and returns read data tagged to the originating port.
module xy_bin_arbiter #(
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_WAIT     = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [2:0]  we,
   input  logic [18:0] addr0,
   input  logic [18:0] addr1,
   input  logic [18:0] addr2,
   input  logic [2:0]  din1,
   input  logic [2:0]  din2,
   output logic [2:0]  gnt,
   output logic [2:0]  rvalid,
   output logic [2:0]  rdata,
   output logic [18:0] bram_addr,
   output logic [2:0]  bram_din,
   output logic        bram_we,
   output logic        bram_en,
   input  logic [2:0]  bram_dout,
   output logic [15:0] grant_count
);

   localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

   logic                         rr_ptr_q;   // 0: port 1 preferred next
   logic [7:0]                   wait1_q;
   logic [7:0]                   wait2_q;
   logic                         ovr_q;      // previous cycle was a starvation override
   logic [READ_LATENCY:0][2:0]   tag_q;      // one-hot port of each read in flight

   logic       rr_win1;
   logic       rr_win2;
   logic       starve;
   logic [2:0] rd_gnt;
   logic       unused_we0;

   assign unused_we0 = we[0];

   always_comb begin
      rr_win1 = req[1] & (~req[2] | ~rr_ptr_q);
      rr_win2 = req[2] & (~req[1] | rr_ptr_q);
      // Overrides are never back-to-back, so port 0 always gets the cycle after one.
      starve  = ~ovr_q & ((rr_win1 & (wait1_q >= MaxWait)) |
                          (rr_win2 & (wait2_q >= MaxWait)));
      gnt = 3'b000;
      if (!reset) begin
         if (req[0] && !starve) begin
            gnt[0] = 1'b1;
         end else if (rr_win1) begin
            gnt[1] = 1'b1;
         end else if (rr_win2) begin
            gnt[2] = 1'b1;
         end
      end
      rd_gnt = gnt & ~{we[2:1], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q    <= 1'b0;
         wait1_q     <= '0;
         wait2_q     <= '0;
         ovr_q       <= 1'b0;
         tag_q       <= '0;
         rvalid      <= '0;
         rdata       <= '0;
         bram_addr   <= '0;
         bram_din    <= '0;
         bram_we     <= 1'b0;
         bram_en     <= 1'b0;
         grant_count <= '0;
      end else begin
         ovr_q <= starve & req[0];

         if (gnt[1]) begin
            rr_ptr_q <= 1'b1;
         end else if (gnt[2]) begin
            rr_ptr_q <= 1'b0;
         end

         if (req[1] && !gnt[1]) begin
            wait1_q <= (wait1_q == 8'hFF) ? wait1_q : wait1_q + 8'd1;
         end else begin
            wait1_q <= '0;
         end
         if (req[2] && !gnt[2]) begin
            wait2_q <= (wait2_q == 8'hFF) ? wait2_q : wait2_q + 8'd1;
         end else begin
            wait2_q <= '0;
         end

         if (|gnt) begin
            bram_en <= 1'b1;
            bram_we <= (gnt[1] & we[1]) | (gnt[2] & we[2]);
            unique case (1'b1)
               gnt[0]: bram_addr <= addr0;
               gnt[1]: begin
                  bram_addr <= addr1;
                  bram_din  <= din1;
               end
               gnt[2]: begin
                  bram_addr <= addr2;
                  bram_din  <= din2;
               end
               default: bram_addr <= bram_addr;
            endcase
            if (grant_count != 16'hFFFF) begin
               grant_count <= grant_count + 16'd1;
            end
         end else begin
            bram_en <= 1'b0;
            bram_we <= 1'b0;
         end

         tag_q  <= {tag_q[READ_LATENCY-1:0], rd_gnt};
         rvalid <= tag_q[READ_LATENCY];
         if (|tag_q[READ_LATENCY]) begin
            rdata <= bram_dout;
         end
      end
   end

endmodule
